// File: rtl/sha256_pkg.sv
// Shared constants, types and sigma rotate/shift amounts for the SHA-256 message schedule.
package sha256_pkg;

  localparam int WORD_W      = 32;
  localparam int BLOCK_WORDS = 16;
  localparam int ROUNDS      = 64;

  localparam int S0_R1 = 7;
  localparam int S0_R2 = 18;
  localparam int S0_SH = 3;
  localparam int S1_R1 = 17;
  localparam int S1_R2 = 19;
  localparam int S1_SH = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

endpackage

// File: rtl/sha256_small_sigma.sv
// Combinational SHA-256 small sigma: ROTR(R1) ^ ROTR(R2) ^ SHR(SH).
// Instantiated once per sigma flavour (s0, s1) with the matching amounts.
module sha256_small_sigma
  import sha256_pkg::*;
#(
  parameter int R1 = 7,
  parameter int R2 = 18,
  parameter int SH = 3
) (
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);

  logic [31:0] w_rot1;
  logic [31:0] w_rot2;
  logic [31:0] w_shr;

  assign w_rot1 = (i_x >> R1) | (i_x << (32 - R1));
  assign w_rot2 = (i_x >> R2) | (i_x << (32 - R2));
  assign w_shr  = i_x >> SH;
  assign o_y    = w_rot1 ^ w_rot2 ^ w_shr;

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, streams W[0..ROUNDS-1] using a 16-entry circular buffer.
// Define MSG_SCHED_ABORT_EN to add a synchronous abort input that returns the engine to IDLE.
module sha256_msg_schedule #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_WORDS = 16,
  parameter int ROUNDS      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [5:0]        out_index,
  output logic              busy,
  output logic              block_done
`ifdef MSG_SCHED_ABORT_EN
  ,
  input  logic              abort
`endif
);

  import sha256_pkg::*;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [4:0]        r_cnt;
  logic [5:0]        r_t;
  logic [WORD_W-1:0] r_buf [BLOCK_WORDS];
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_word;
  logic [5:0]        r_out_index;
  logic              r_block_done;

  logic              w_abort;
  logic              w_in_acc;
  logic              w_out_acc;
  logic              w_last_in;
  logic              w_last_out;
  logic [5:0]        w_t1;
  logic [3:0]        w_nx_idx;
  logic [3:0]        w_m2_idx;
  logic [3:0]        w_m7_idx;
  logic [3:0]        w_m15_idx;
  logic [WORD_W-1:0] w_s0;
  logic [WORD_W-1:0] w_s1;
  logic [WORD_W-1:0] w_exp;
  logic [WORD_W-1:0] w_next;

`ifdef MSG_SCHED_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign in_ready   = (r_state != EMIT);
  assign w_in_acc   = in_valid & in_ready;
  assign w_out_acc  = r_out_valid & out_ready;
  assign w_last_in  = (r_state == LOAD) && (r_cnt == 5'(BLOCK_WORDS - 1));
  assign w_last_out = (r_t == 6'(ROUNDS - 1));

  // Buffer slot for W[j] is j mod 16; with j = t+1 the taps are j-2, j-7, j-15 and j-16 (== j).
  assign w_t1      = r_t + 6'd1;
  assign w_nx_idx  = w_t1[3:0];
  assign w_m2_idx  = 4'(r_t - 6'd1);
  assign w_m7_idx  = 4'(r_t - 6'd6);
  assign w_m15_idx = 4'(r_t - 6'd14);

  sha256_small_sigma #(.R1(S0_R1), .R2(S0_R2), .SH(S0_SH)) u_s0 (
    .i_x (r_buf[w_m15_idx]),
    .o_y (w_s0)
  );

  sha256_small_sigma #(.R1(S1_R1), .R2(S1_R2), .SH(S1_SH)) u_s1 (
    .i_x (r_buf[w_m2_idx]),
    .o_y (w_s1)
  );

  assign w_exp  = w_s1 + r_buf[w_m7_idx] + w_s0 + r_buf[w_nx_idx];
  assign w_next = (w_t1 < 6'(BLOCK_WORDS)) ? r_buf[w_nx_idx] : w_exp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_in_acc) w_state_nxt = LOAD;
        LOAD:    if (w_in_acc && w_last_in) w_state_nxt = EMIT;
        EMIT:    if (w_out_acc && w_last_out) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_t          <= '0;
      r_out_valid  <= 1'b0;
      r_out_word   <= '0;
      r_out_index  <= '0;
      r_block_done <= 1'b0;
      for (int i = 0; i < BLOCK_WORDS; i++) r_buf[i] <= '0;
    end else begin
      r_block_done <= 1'b0;
      if (w_abort) begin
        r_cnt       <= '0;
        r_t         <= '0;
        r_out_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_in_acc) begin
              r_buf[0] <= in_word;
              r_cnt    <= 5'd1;
            end
          end
          LOAD: begin
            if (w_in_acc) begin
              r_buf[r_cnt[3:0]] <= in_word;
              r_cnt             <= r_cnt + 5'd1;
              if (w_last_in) begin
                // W[0] was captured in IDLE, so it is safe to present it directly.
                r_out_word  <= r_buf[0];
                r_out_valid <= 1'b1;
                r_out_index <= '0;
                r_t         <= '0;
                r_cnt       <= '0;
              end
            end
          end
          EMIT: begin
            if (w_out_acc) begin
              if (w_last_out) begin
                r_out_valid  <= 1'b0;
                r_block_done <= 1'b1;
                r_t          <= '0;
              end else begin
                r_t         <= w_t1;
                r_out_index <= w_t1;
                r_out_word  <= w_next;
                if (w_t1 >= 6'(BLOCK_WORDS)) r_buf[w_nx_idx] <= w_next;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_word   = r_out_word;
  assign out_index  = r_out_index;
  assign busy       = (r_state != IDLE);
  assign block_done = r_block_done;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Directed bench for sha256_msg_schedule: "abc" block, backpressure, gapped input, reset, back-to-back blocks.
module tb_sha256_msg_schedule;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        busy;
  logic        block_done;
`ifdef MSG_SCHED_ABORT_EN
  logic        abort;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int cyc_start;
  int cyc_done;

  logic [31:0] blk  [16];
  logic [31:0] expw [64];
  logic [31:0] got  [64];

  sha256_msg_schedule dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_word   (out_word),
    .out_index  (out_index),
    .busy       (busy),
    .block_done (block_done)
`ifdef MSG_SCHED_ABORT_EN
    ,
    .abort      (abort)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule over a full 64-entry array.
  task automatic build_model();
    logic [31:0] w [64];
    for (int j = 0; j < 16; j++) w[j] = blk[j];
    for (int j = 16; j < 64; j++)
      w[j] = ssig1(w[j-2]) + w[j-7] + ssig0(w[j-15]) + w[j-16];
    for (int j = 0; j < 64; j++) expw[j] = w[j];
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic load_random();
    for (int i = 0; i < 16; i++) blk[i] = $urandom();
  endtask

  // Sends blk[first..last-1]; called and returns on a negedge.
  task automatic send_block(input int gap, input int first, input int last);
    int b;
    for (int i = first; i < last; i++) begin
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(negedge clock);
      end
      in_valid = 1'b1;
      in_word  = blk[i];
      b = 0;
      while (!in_ready && b < 50) begin
        @(negedge clock);
        b++;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    if (last == 16) begin
      chk("emit_start_valid", out_valid, 1);
      chk("emit_start_index", out_index, 0);
      chk("emit_start_in_ready", in_ready, 0);
      chk("emit_start_busy", busy, 1);
    end
  endtask

  // Consumes the schedule until index `stop` is presented (stop>=64 means the full block).
  task automatic recv_block(input int bp, input int stop);
    int idx = 0;
    int budget = 0;
    while (idx < 64 && idx != stop && budget < 3000) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (out_valid) begin
        chk("out_index", out_index, idx);
        chk("out_word", out_word, expw[idx]);
        chk("in_ready_emit", in_ready, 0);
        if (out_ready) begin
          got[idx] = out_word;
          idx++;
        end
      end
      @(negedge clock);
      budget++;
    end
    out_ready = 1'b0;
    if (stop >= 64) begin
      chk("recv_complete", idx, 64);
      chk("block_done_pulse", block_done, 1);
      chk("out_valid_after", out_valid, 0);
      chk("idle_in_ready", in_ready, 1);
      chk("idle_busy", busy, 0);
      cyc_done = cyc;
      @(negedge clock);
      chk("block_done_once", block_done, 0);
    end else begin
      chk("recv_reached_stop", idx, stop);
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_word   = 32'h0;
    out_ready = 1'b0;
`ifdef MSG_SCHED_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_busy", busy, 0);
    chk("rst_block_done", block_done, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    @(negedge clock);

    // "abc" block at full rate
    load_abc();
    build_model();
    cyc_start = cyc;
    send_block(0, 0, 16);
    recv_block(0, 64);
    chk("abc_W16", got[16], 32'h61626380);
    chk("abc_W17", got[17], 32'h000F0000);
    chk("abc_cycles", cyc_done - cyc_start + 1, 81);

    // same block under random backpressure
    send_block(0, 0, 16);
    recv_block(1, 64);

    // gapped input; next block's first word held during EMIT must not be lost
    send_block(2, 0, 16);
    load_random();
    in_valid = 1'b1;
    in_word  = blk[0];
    recv_block(0, 64);
    build_model();
    send_block(0, 1, 16);
    recv_block(1, 64);

    // back-to-back random block with no residue from the previous one
    load_random();
    build_model();
    send_block(0, 0, 16);
    recv_block(0, 64);

    // reset in the middle of EMIT
    load_abc();
    build_model();
    send_block(0, 0, 16);
    recv_block(0, 20);
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_word", out_word, 0);
    chk("midrst_out_index", out_index, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_block_done", block_done, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send_block(0, 0, 16);
    recv_block(0, 64);

`ifdef MSG_SCHED_ABORT_EN
    // abort at cnt=7 with a coincident input word that must not be counted
    send_block(0, 0, 7);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_word  = 32'hDEADBEEF;
    @(negedge clock);
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("abort_load_busy", busy, 0);
    send_block(0, 0, 16);
    recv_block(0, 64);

    // abort coincident with an output accept
    send_block(0, 0, 16);
    recv_block(0, 5);
    out_ready = 1'b1;
    abort     = 1'b1;
    @(negedge clock);
    abort     = 1'b0;
    out_ready = 1'b0;
    chk("abort_emit_valid", out_valid, 0);
    chk("abort_emit_index", out_index, 5);
    chk("abort_emit_busy", busy, 0);
    chk("abort_emit_done", block_done, 0);
    send_block(0, 0, 16);
    recv_block(0, 64);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
